// File: rtl/cameralink_line_framer.sv
// CameraLink frame/line framer: qualifies FVAL/LVAL/DVAL beats into framed pixel beats
// with sof/eol/eof sideband, geometry error flags and a 2-entry registered skid buffer.
//
// state | meaning
// IDLE  | not capturing; waits for enable with FVAL low
// ARMED | waiting for FVAL to rise on the next frame
// FRAME | capturing beats of the current frame
// SKIP  | eof delivered; ignoring the rest of FVAL
module cameralink_line_framer #(
   parameter int PIX_W = 12,
   parameter int TAPS  = 2,
   parameter int CNT_W = 16
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    enable,
   input  logic [CNT_W-1:0]        line_width,
   input  logic [CNT_W-1:0]        frame_height,
   input  logic [TAPS*PIX_W-1:0]   in_data,
   input  logic                    in_fval,
   input  logic                    in_lval,
   input  logic                    in_dval,
   output logic [TAPS*PIX_W-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_sof,
   output logic                    out_eol,
   output logic                    out_eof,
   output logic [CNT_W-1:0]        line_cnt,
   output logic                    frame_active,
   output logic                    err_short_line,
   output logic                    err_long_line,
   output logic                    err_overflow,
   input  logic                    err_clr
);

   localparam int DW = TAPS*PIX_W;
   localparam int EW = DW + 3;
   localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);

   typedef enum logic [1:0] {IDLE, ARMED, FRAME, SKIP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  lw_q, fh_q;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
   logic              lval_q;
   logic              sof_pend_q, sof_pend_d;
   logic              line_done_q, line_done_d;
   logic [EW-1:0]     ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]        count_q, count_d;
   logic              err_short_q, err_long_q, err_ovf_q;

   logic              beat, take, too_long, is_eol, is_eof, short_line, lval_fall;
   logic              frame_entry, push, pop, ovf;
   logic [CNT_W-1:0]  pix_nxt;
   logic [EW-1:0]     new_ent;

   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      line_cnt_d  = line_cnt_q;
      sof_pend_d  = sof_pend_q;
      line_done_d = line_done_q;
      ent0_d      = ent0_q;
      ent1_d      = ent1_q;
      count_d     = count_q;

      beat       = (state_q == FRAME) && in_fval && in_lval && in_dval;
      pix_nxt    = pix_cnt_q + TAPS_C;
      // after eol the rest of the LVAL pulse is surplus, even though pix_cnt restarted at 0
      too_long   = line_done_q || (pix_cnt_q >= lw_q);
      take       = beat && !too_long;
      is_eol     = (pix_nxt == lw_q);
      is_eof     = is_eol && (line_cnt_q == fh_q - CNT_W'(1));
      lval_fall  = (state_q == FRAME) && lval_q && !in_lval;
      short_line = lval_fall && (pix_cnt_q != '0) && (pix_cnt_q < lw_q);
      new_ent    = {sof_pend_q, is_eol, is_eof, in_data};

      case (state_q)
         IDLE:  if (enable && !in_fval) state_d = ARMED;
         ARMED: if (!enable) state_d = IDLE;
                else if (in_fval) state_d = FRAME;
         FRAME: if (!in_fval) state_d = enable ? ARMED : IDLE;
                else if (take && is_eof) state_d = SKIP;
         SKIP:  if (!in_fval) state_d = enable ? ARMED : IDLE;
         default: state_d = IDLE;
      endcase
      frame_entry = (state_q == ARMED) && (state_d == FRAME);

      if (frame_entry) begin
         pix_cnt_d   = '0;
         line_cnt_d  = '0;
         sof_pend_d  = 1'b1;
         line_done_d = 1'b0;
      end else if (take) begin
         sof_pend_d = 1'b0;
         if (is_eol) begin
            pix_cnt_d   = '0;
            line_cnt_d  = line_cnt_q + CNT_W'(1);
            line_done_d = 1'b1;
         end else begin
            pix_cnt_d = pix_nxt;
         end
      end else if (lval_fall) begin
         line_done_d = 1'b0;
         if (short_line) begin
            pix_cnt_d  = '0;
            line_cnt_d = line_cnt_q + CNT_W'(1);
         end
      end

      pop  = (count_q != 2'd0) && out_ready;
      push = take && ((count_q != 2'd2) || pop);
      ovf  = take && (count_q == 2'd2) && !pop;

      case (count_q)
         2'd0: if (push) begin
            ent0_d  = new_ent;
            count_d = 2'd1;
         end
         2'd1: if (pop && push) ent0_d = new_ent;
               else if (pop) count_d = 2'd0;
               else if (push) begin
                  ent1_d  = new_ent;
                  count_d = 2'd2;
               end
         default: if (pop) begin
            ent0_d = ent1_q;
            if (push) ent1_d = new_ent;
            else count_d = 2'd1;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         lw_q        <= '0;
         fh_q        <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= '0;
         lval_q      <= 1'b0;
         sof_pend_q  <= 1'b0;
         line_done_q <= 1'b0;
         ent0_q      <= '0;
         ent1_q      <= '0;
         count_q     <= 2'd0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         line_cnt_q  <= line_cnt_d;
         lval_q      <= in_lval;
         sof_pend_q  <= sof_pend_d;
         line_done_q <= line_done_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
         count_q     <= count_d;
         if (frame_entry) begin
            lw_q <= line_width;
            fh_q <= frame_height;
         end
         err_short_q <= !err_clr && (err_short_q || short_line);
         err_long_q  <= !err_clr && (err_long_q || (beat && too_long));
         err_ovf_q   <= !err_clr && (err_ovf_q || ovf);
      end
   end

   assign out_valid      = (count_q != 2'd0);
   assign out_data       = ent0_q[DW-1:0];
   assign out_sof        = out_valid && ent0_q[DW+2];
   assign out_eol        = out_valid && ent0_q[DW+1];
   assign out_eof        = out_valid && ent0_q[DW];
   assign line_cnt       = line_cnt_q;
   assign frame_active   = (state_q == FRAME) || (state_q == SKIP);
   assign err_short_line = err_short_q;
   assign err_long_line  = err_long_q;
   assign err_overflow   = err_ovf_q;

endmodule

// File: doc/cameralink_line_framer.md
CAMERALINK_LINE_FRAMER -- requirements
Module: cameralink_line_framer

Interface
REQ-001 Parameter PIX_W, default 12, bits per pixel (8, 10, 12 or 14).
REQ-002 Parameter TAPS, default 2, pixels per input beat (1..4).
REQ-003 Parameter CNT_W, default 16, width of pixel/line counters.
REQ-004 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  arms capture of the next frame.
REQ-007 line_width  in  CNT_W  pixels per line, nonzero multiple of TAPS.
REQ-008 frame_height  in  CNT_W  lines per frame, nonzero.
REQ-009 in_data  in  TAPS*PIX_W  pixel beat, tap 0 in LSBs.
REQ-010 in_fval / in_lval / in_dval  in  1 each  CameraLink framing strobes; no backpressure.
REQ-011 out_data  out  TAPS*PIX_W  registered pixel beat.
REQ-012 out_valid  out  1 / out_ready  in  1  valid-ready handshake.
REQ-013 out_sof / out_eol / out_eof  out  1 each  sideband qualified by out_valid.
REQ-014 line_cnt  out  CNT_W  completed lines in the current frame.
REQ-015 frame_active  out  1  high in FRAME and SKIP states.
REQ-016 err_short_line / err_long_line / err_overflow  out  1 each  sticky error flags.
REQ-017 err_clr  in  1  synchronous clear of all sticky errors.

Function
REQ-018 FSM states IDLE, ARMED, FRAME, SKIP; reset state IDLE.
REQ-019 IDLE -> ARMED when enable=1 and in_fval=0 in the same cycle; never arm mid-frame.
REQ-020 ARMED -> IDLE if enable=0; ARMED -> FRAME on in_fval=1.
REQ-021 FRAME -> SKIP after the eof beat is accepted; FRAME or SKIP -> ARMED on in_fval=0 if enable=1, else -> IDLE.
REQ-022 Beat = cycle in FRAME with in_fval & in_lval & in_dval all 1; beats outside FRAME are discarded silently.
REQ-023 pix_cnt adds TAPS per beat; a beat with pix_cnt+TAPS = line_width carries out_eol, then pix_cnt <- 0 and line_cnt +1.
REQ-024 Beat with pix_cnt >= line_width is dropped and sets err_long_line.
REQ-025 in_lval falling with 0 < pix_cnt < line_width: set err_short_line, pix_cnt <- 0, line_cnt +1, no eol emitted.
REQ-026 First beat after FRAME entry carries out_sof; eol beat with line_cnt = frame_height-1 also carries out_eof.
REQ-027 Output path: 2-entry skid buffer; out_data/sideband registered; beat accepted at cycle N with buffer empty gives out_valid at N+1.
REQ-028 Transfer when out_valid & out_ready; out_valid, out_data and sideband hold stable while out_ready=0.
REQ-029 Beat arriving with both entries occupied and no transfer that cycle is dropped, sets err_overflow; counters still advance.
REQ-030 Simultaneous buffer pop and push with two entries occupied is accepted without loss.
REQ-031 err_clr has priority over a same-cycle error set; errors persist across frames.
REQ-032 line_cnt and pix_cnt cleared on FRAME entry; line_cnt holds its final value after the frame.
REQ-033 in_fval falling in FRAME before eof: leave per REQ-021, buffered beats still drain, no eof generated.
REQ-034 line_width/frame_height sampled on FRAME entry; changes mid-frame have no effect.

Reset
REQ-035 sys_rst asserted: state IDLE, counters 0, buffer empty, out_valid/out_sof/out_eol/out_eof/frame_active/errors 0, out_data 0.
REQ-036 Reset mid-frame discards buffered beats; after release, capture restarts only through IDLE -> ARMED on in_fval=0.

Verification
REQ-037 TAPS=2, line_width=8, frame_height=3, out_ready=1: 12 beats -> 12 outputs, sof on 1st, eol on 4/8/12, eof on 12th, line_cnt=3.
REQ-038 Line of 6 beats with line_width=8 -> beats 5-6 dropped, err_long_line=1, eol still on beat 4.
REQ-039 in_lval falls after 2 beats, line_width=8 -> err_short_line=1, line_cnt=1, no eol; next line eol on its 4th beat.
REQ-040 out_ready=0 for 5 consecutive beats -> first 2 held, 3 dropped, err_overflow=1; err_clr -> flag 0 next cycle.
REQ-041 enable=1 while in_fval=1 at reset release -> no output until in_fval goes 0 then 1; second frame captured intact.
REQ-042 sys_rst pulse mid-line with 2 entries buffered -> out_valid=0 immediately, no stale beat after release.
